adventure_game_fsm: RTL and testbench

Parametrised next-generation adventure-game controller: the room map FSM and the sword-tracking logic are merged into one block.
Adds edge-detected direction buttons, single-direction move validation, a configurable lives count with respawn, and an optional move limit.
Sits between the debounced board buttons (n/s/e/w) and the LED/seven-segment display logic.

---
 rtl/adventure_pkg.sv | 49 ++++
 rtl/button_edge.sv | 29 ++
 rtl/adventure_game_fsm.sv | 101 ++++++++++
 tb/tb_adventure_game_fsm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/adventure_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adventure_pkg
// Description : Shared types for the adventure-game controller: the room
//               encoding, direction bit indices into the {n,s,e,w} button
//               vector, and the room-map lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package adventure_pkg;

  typedef enum logic [2:0] {
    CAVE      = 3'd0,
    TUNNEL    = 3'd1,
    RIVER     = 3'd2,
    STASH     = 3'd3,
    DEN       = 3'd4,
    VAULT     = 3'd5,
    GRAVEYARD = 3'd6
  } room_t;

  localparam int DIR_N = 3;
  localparam int DIR_S = 2;
  localparam int DIR_E = 1;
  localparam int DIR_W = 0;

  // Destination for a single-direction press. A direction with no exit
  // returns the current room, so "target != current" means a legal move.
  function automatic room_t map_move(room_t cur, logic [3:0] press);
    room_t nxt;
    nxt = cur;
    case (cur)
      CAVE:   if (press[DIR_E]) nxt = TUNNEL;
      TUNNEL: begin
        if (press[DIR_S]) nxt = RIVER;
        else if (press[DIR_W]) nxt = CAVE;
      end
      RIVER: begin
        if (press[DIR_N]) nxt = TUNNEL;
        else if (press[DIR_E]) nxt = DEN;
        else if (press[DIR_W]) nxt = STASH;
      end
      STASH:  if (press[DIR_E]) nxt = RIVER;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_edge.sv
`default_nettype none
// ============================================================================
// Module      : button_edge
// Description : Rising-edge detector for a vector of level buttons.
//               prev holds last cycle's sample; rise = din & ~prev.
// Ports       : clk, reset (async, active-high), din[WIDTH] level inputs,
//               prev[WIDTH] registered previous sample, rise[WIDTH] pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] prev,
  output logic [WIDTH-1:0] rise
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= din;
  end

  // Cleared prev after reset means a button held through reset is a press.
  assign rise = din & ~prev;

endmodule
`default_nettype wire

// File: rtl/adventure_game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : adventure_game_fsm
// Description : Adventure-game controller: room-map FSM, sword tracking,
//               lives with respawn and optional accepted-move limit.
// Ports       : clk, reset (async, active-high), n/s/e/w level buttons,
//               room (room_t), sw sword held, win (VAULT), d (GRAVEYARD),
//               lives remaining, moves accepted-move count (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module adventure_game_fsm
  import adventure_pkg::*;
#(
  parameter int NUM_LIVES = 3,
  parameter int MAX_MOVES = 0,
  parameter int MOVE_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n,
  input  logic              s,
  input  logic              e,
  input  logic              w,
  output room_t             room,
  output logic              sw,
  output logic              win,
  output logic              d,
  output logic [2:0]        lives,
  output logic [MOVE_W-1:0] moves
);

  localparam logic [2:0]        LIVES_INIT = 3'(NUM_LIVES);
  localparam logic [MOVE_W-1:0] MOVE_LIMIT = MOVE_W'(MAX_MOVES);
  localparam logic [MOVE_W-1:0] MOVE_SAT   = '1;

  logic [3:0] buttons;
  logic [3:0] prev;
  logic [3:0] press;
  logic       one_hot;
  logic       limit_hit;
  room_t      target;
  logic       unused_prev;

  assign buttons = {n, s, e, w};

  button_edge #(.WIDTH(4)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (buttons),
    .prev  (prev),
    .rise  (press)
  );

  // prev is only needed inside the edge detector.
  assign unused_prev = ^prev;

  assign one_hot   = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);
  assign limit_hit = (MAX_MOVES != 0) && (moves == MOVE_LIMIT);
  assign target    = map_move(room, press);

  assign win = (room == VAULT);
  assign d   = (room == GRAVEYARD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      room  <= CAVE;
      sw    <= 1'b0;
      lives <= LIVES_INIT;
      moves <= '0;
    end else begin
      case (room)
        CAVE, TUNNEL, RIVER, STASH: begin
          // Exhausted move budget wins over any press this cycle.
          if (limit_hit) begin
            room  <= GRAVEYARD;
            lives <= 3'd0;
          end else if (one_hot && (target != room)) begin
            room <= target;
            if (moves != MOVE_SAT) moves <= moves + MOVE_W'(1);
            if (target == STASH) sw <= 1'b1;
          end
        end
        DEN: begin
          if (sw) begin
            room <= VAULT;
          end else if (lives > 3'd1) begin
            room  <= CAVE;
            lives <= lives - 3'd1;
          end else begin
            room  <= GRAVEYARD;
            lives <= 3'd0;
          end
        end
        VAULT, GRAVEYARD: ;
        default: room <= CAVE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adventure_game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_adventure_game_fsm
// Description : Table-driven bench for adventure_game_fsm. Two instances:
//               dut0 with no move limit, dut1 with MAX_MOVES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adventure_game_fsm;
  import adventure_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;

  room_t      room0, room1;
  logic       sw0, sw1, win0, win1, d0, d1;
  logic [2:0] lives0, lives1;
  logic [7:0] moves0, moves1;

  always #5 clk = ~clk;

  adventure_game_fsm #(.NUM_LIVES(3), .MAX_MOVES(0), .MOVE_W(8)) dut0 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .room(room0), .sw(sw0), .win(win0), .d(d0), .lives(lives0), .moves(moves0)
  );

  adventure_game_fsm #(.NUM_LIVES(3), .MAX_MOVES(4), .MOVE_W(8)) dut1 (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
    .room(room1), .sw(sw1), .win(win1), .d(d1), .lives(lives1), .moves(moves1)
  );

  typedef struct {
    bit         rst;    // apply reset for this vector
    bit         sel;    // 0: check dut0, 1: check dut1
    logic [3:0] btn;    // {n,s,e,w}
    logic [2:0] room;
    logic       sw;
    logic [2:0] lives;
    logic [7:0] moves;
  } vec_t;

  localparam logic [3:0] BN = 4'b1000, BS = 4'b0100, BE = 4'b0010,
                         BW = 4'b0001, B0 = 4'b0000;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void add(bit rst, bit sel, logic [3:0] btn, logic [2:0] rm,
                              logic swx, logic [2:0] lv, logic [7:0] mv);
    vec_t v;
    v = '{rst, sel, btn, rm, swx, lv, mv};
    vecs.push_back(v);
  endfunction

  task automatic compare(input string tag);
    vec_t       x;
    logic [2:0] a_room, a_lives;
    logic       a_sw, a_win, a_d, x_win, x_d;
    logic [7:0] a_moves;
    x = sb.pop_front();
    if (x.sel) begin
      a_room = room1; a_sw = sw1; a_win = win1; a_d = d1; a_lives = lives1; a_moves = moves1;
    end else begin
      a_room = room0; a_sw = sw0; a_win = win0; a_d = d0; a_lives = lives0; a_moves = moves0;
    end
    x_win = (x.room == 3'd5);
    x_d   = (x.room == 3'd6);
    n_vec++;
    if (a_room !== x.room || a_sw !== x.sw || a_lives !== x.lives ||
        a_moves !== x.moves || a_win !== x_win || a_d !== x_d) begin
      n_fail++;
      $display("FAIL %s dut%0d: got room=%0d sw=%0b lives=%0d moves=%0d win=%0b d=%0b, expected room=%0d sw=%0b lives=%0d moves=%0d win=%0b d=%0b",
               tag, x.sel, a_room, a_sw, a_lives, a_moves, a_win, a_d,
               x.room, x.sw, x.lives, x.moves, x_win, x_d);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; results sampled 1 unit
  // after the edge that consumed them.
  task automatic apply(input vec_t v, input int idx);
    {n, s, e, w} = v.btn;
    if (v.rst) begin
      reset = 1'b1;
      #2;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (v.rst) reset = 1'b0;
    compare($sformatf("vec%0d", idx));
  endtask

  initial begin
    // Win path, each press held 2 cycles then released.
    add(1,0,B0,0,0,3,0);
    add(0,0,BE,1,0,3,1); add(0,0,BE,1,0,3,1); add(0,0,B0,1,0,3,1);
    add(0,0,BS,2,0,3,2); add(0,0,BS,2,0,3,2); add(0,0,B0,2,0,3,2);
    add(0,0,BW,3,1,3,3); add(0,0,BW,3,1,3,3); add(0,0,B0,3,1,3,3);
    add(0,0,BE,2,1,3,4); add(0,0,BE,2,1,3,4); add(0,0,B0,2,1,3,4);
    add(0,0,BE,4,1,3,5); add(0,0,BE,5,1,3,5); add(0,0,B0,5,1,3,5);
    add(0,0,BN,5,1,3,5);
    // Death with respawn, three times.
    add(1,0,B0,0,0,3,0);
    for (int k = 0; k < 3; k++) begin
      add(0,0,BE,1,0,3-k,3*k+1); add(0,0,B0,1,0,3-k,3*k+1);
      add(0,0,BS,2,0,3-k,3*k+2); add(0,0,B0,2,0,3-k,3*k+2);
      add(0,0,BE,4,0,3-k,3*k+3);
      if (k < 2) add(0,0,B0,0,0,2-k,3*k+3);
      else       add(0,0,B0,6,0,0,9);
    end
    add(0,0,BE,6,0,0,9); add(0,0,B0,6,0,0,9); add(0,0,BN,6,0,0,9);
    // Held button and multi-press.
    add(1,0,B0,0,0,3,0);
    for (int k = 0; k < 10; k++) add(0,0,BE,1,0,3,1);
    add(0,0,B0,1,0,3,1);
    add(0,0,BS|BW,1,0,3,1); add(0,0,BS|BW,1,0,3,1); add(0,0,B0,1,0,3,1);
    add(0,0,BS,2,0,3,2);
    // Illegal directions from CAVE.
    add(1,0,B0,0,0,3,0);
    add(0,0,BN,0,0,3,0); add(0,0,B0,0,0,3,0);
    add(0,0,BS,0,0,3,0); add(0,0,B0,0,0,3,0);
    add(0,0,BW,0,0,3,0); add(0,0,B0,0,0,3,0);
    // Move limit of 4 on dut1; death preempts the e press.
    add(1,1,B0,0,0,3,0);
    add(0,1,BE,1,0,3,1); add(0,1,B0,1,0,3,1);
    add(0,1,BW,0,0,3,2); add(0,1,B0,0,0,3,2);
    add(0,1,BE,1,0,3,3); add(0,1,B0,1,0,3,3);
    add(0,1,BW,0,0,3,4);
    add(0,1,BE,6,0,0,4); add(0,1,B0,6,0,0,4);
    // Reach RIVER with sword and two lives on dut0.
    add(1,0,B0,0,0,3,0);
    add(0,0,BE,1,0,3,1); add(0,0,B0,1,0,3,1);
    add(0,0,BS,2,0,3,2); add(0,0,B0,2,0,3,2);
    add(0,0,BE,4,0,3,3); add(0,0,B0,0,0,2,3);
    add(0,0,BE,1,0,2,4); add(0,0,B0,1,0,2,4);
    add(0,0,BS,2,0,2,5); add(0,0,B0,2,0,2,5);
    add(0,0,BW,3,1,2,6); add(0,0,B0,3,1,2,6);
    add(0,0,BE,2,1,2,7); add(0,0,B0,2,1,2,7);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Async reset between edges clears everything before the next edge.
    begin
      vec_t v;
      #3;
      reset = 1'b1;
      #1;
      v = '{1'b0, 1'b0, B0, 3'd0, 1'b0, 3'd3, 8'd0};
      sb.push_back(v);
      compare("async_reset");
      // Button held through reset release counts as a press.
      e = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      v = '{1'b0, 1'b0, BE, 3'd1, 1'b0, 3'd3, 8'd1};
      sb.push_back(v);
      @(posedge clk);
      #1;
      compare("held_through_reset");
      e = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
